// File: rtl/core_config_pkg.sv
// Core-wide configuration: data/register widths and the writeback collector types.
package core_config_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef struct packed {
        logic [XLEN-1:0]       data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  error;
    } wb_entry_t;

    typedef logic [0:0] collector_state_t;

    localparam collector_state_t C_IDLE = 1'b0;
    localparam collector_state_t C_HOLD = 1'b1;

endpackage

// File: rtl/alu2_wb_collector_fifo.sv
// wb_fifo: small synchronous FIFO of writeback entries with flush; the head is
// zeroed while empty so the writeback port never shows stale data.
module wb_fifo
    import core_config_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_push_ok = push & ~full & ~flush;
    assign w_pop_ok  = pop & ~empty & ~flush;
    assign head      = empty ? '0 : r_mem[r_rd_ptr];

    // Storage carries data only; validity comes from the count.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu2_wb_collector.sv
// Collects multi-cycle ALU results into a writeback FIFO with a one-cycle ack.
// Optional destination scoreboard enabled by defining ALU2_WB_SCOREBOARD_EN.
module alu2_wb_collector
    import core_config_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid,
    input  logic [XLEN-1:0]               alu_res,
    input  logic [REG_ADDR_W-1:0]         alu_rd,
    input  logic                          alu_error,
    output logic                          alu_clear,
    input  logic                          issue_valid,
    input  logic [REG_ADDR_W-1:0]         issue_rd,
    input  logic                          flush,
    output logic                          wb_valid,
    input  logic                          wb_ready,
    output logic [REG_ADDR_W-1:0]         wb_rd,
    output logic [XLEN-1:0]               wb_data,
    output logic                          wb_error,
    output logic [(1<<REG_ADDR_W)-1:0]    pending,
    output logic                          full,
    output logic                          empty
);

    localparam int unsigned NREG = 1 << REG_ADDR_W;

    collector_state_t r_state;
    collector_state_t w_state_nxt;
    wb_entry_t        w_push_data;
    wb_entry_t        w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_wb_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // HOLD masks the ALU's valid for one cycle after an ack to avoid a double capture.
    always_comb begin
        w_state_nxt = r_state;
        alu_clear   = 1'b0;
        case (r_state)
            C_IDLE: begin
                if (alu_valid && (!w_full || flush)) begin
                    alu_clear = 1'b1;
                    if (!flush) begin
                        w_state_nxt = C_HOLD;
                    end
                end
            end
            C_HOLD:  w_state_nxt = C_IDLE;
            default: w_state_nxt = C_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = C_IDLE;
        end
    end

    // Writes to x0 without an error carry nothing worth writing back.
    assign w_push = alu_clear & ~flush & ((alu_rd != '0) | alu_error);
    assign w_push_data.data  = alu_res;
    assign w_push_data.rd    = alu_rd;
    assign w_push_data.error = alu_error;

    assign w_wb_fire = wb_valid & wb_ready;
    assign w_pop     = w_wb_fire & ~flush;

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (wb_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign wb_valid = ~w_empty;
    assign wb_rd    = w_head.rd;
    assign wb_data  = w_head.data;
    assign wb_error = w_head.error;
    assign full     = w_full;
    assign empty    = w_empty;

`ifdef ALU2_WB_SCOREBOARD_EN
    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_pending_nxt;

    // Issue set is applied after writeback clear so a same-cycle reissue stays pending.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_wb_fire) begin
            w_pending_nxt[wb_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            w_pending_nxt[issue_rd] = 1'b1;
        end
        if (flush) begin
            w_pending_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign pending = r_pending;
`else
    logic w_unused_issue;
    assign w_unused_issue = ^{issue_valid, issue_rd};
    assign pending        = NREG'(0);
`endif

endmodule

// File: doc/alu2_wb_collector.md
# alu2_wb_collector

Result collector sitting directly downstream of the multi-cycle ALU (mul/div/shift unit). It captures each result the ALU holds on its output (valid, res, rd, error) and returns a one-cycle clear so the ALU can go idle. Results are buffered in a small FIFO and presented to the register-file writeback port through a valid/ready handshake. An optional scoreboard tracks destination registers with an operation in flight.

## Interface
- XLEN, core_config_pkg::XLEN (32): data width.
- REG_ADDR_W, core_config_pkg::REG_ADDR_W (5): register address width.
- DEPTH, 2: FIFO entries; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- alu_valid  in  1  ALU result held valid; stays high until alu_clear is seen.
- alu_res  in  XLEN  ALU result.
- alu_rd  in  REG_ADDR_W  destination register.
- alu_error  in  1  ALU error flag (divide by zero), sampled with alu_valid.
- alu_clear  out  1  one-cycle acknowledge to the ALU.
- issue_valid  in  1  operation dispatched to the ALU this cycle (scoreboard).
- issue_rd  in  REG_ADDR_W  destination of the dispatched operation.
- flush  in  1  synchronous pipeline flush.
- wb_valid  out  1  writeback entry available.
- wb_ready  in  1  register file accepts the entry.
- wb_rd  out  REG_ADDR_W  writeback address.
- wb_data  out  XLEN  writeback data.
- wb_error  out  1  error flag of the entry; status only, no trap.
- pending  out  2**REG_ADDR_W  scoreboard bitmap; bit i set means x[i] has a write in flight.
- full / empty  out  1  FIFO status.

## Operation
- Capture FSM has two states:
  - IDLE: capture when alu_valid & !full.
  - HOLD: entered for exactly one cycle after a capture. It ignores alu_valid, so the ALU's one-cycle valid-drop latency cannot cause a double capture. It then returns to IDLE.
- alu_clear is combinational: (state==IDLE) & alu_valid & (!full | flush).
- On capture, {alu_res, alu_rd, alu_error} is pushed on the same edge.
- Entries with alu_rd==0 and alu_error==0 are acknowledged but not pushed.
- Pop happens on wb_valid & wb_ready. wb_* always reflect the FIFO head.
- Empty FIFO: wb_valid=0 and wb_rd, wb_data, wb_error are 0.
- Full FIFO: a push is blocked even if a pop happens the same cycle. alu_clear stays low and the ALU keeps holding its result.
- Simultaneous push and pop with 0 < count < DEPTH: both occur and count is unchanged.
- Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits wide.
- flush:
  - Empties the FIFO and forces state to IDLE.
  - A result presented the same cycle is still acknowledged (alu_clear=1) but discarded, so the ALU never deadlocks.
  - A pop in the flush cycle is suppressed.

## Timing
- Capture to wb_valid: 1 cycle (registered FIFO head).
- Back-to-back ALU results: at most one capture every 2 cycles (capture, HOLD).
- Reset values: state IDLE, alu_clear 0, wb_valid 0, wb_rd 0, wb_data 0, wb_error 0, pending 0, full 0, empty 1, pointers 0.
- Reset mid-operation: all FIFO contents and scoreboard bits are lost. The ALU is reset by the same rst_n.

## Configuration
- Macro: ALU2_WB_SCOREBOARD_EN.
- Defined:
  - issue_valid sets pending[issue_rd], except for x0.
  - A writeback handshake clears pending[wb_rd].
  - Set and clear of the same bit in one cycle: set wins.
  - flush clears all bits. issue_valid is ignored during flush.
- Undefined: pending is tied to 0, and issue_valid/issue_rd are unused.

## Structure
- core_config_pkg gains:
  - typedef wb_entry_t, a packed struct {data XLEN, rd REG_ADDR_W, error}.
  - typedef collector_state_t {C_IDLE, C_HOLD}.
- One sub-module, wb_fifo: parameterised over DEPTH and wb_entry_t, with push/pop/full/empty/flush.
- The FSM and scoreboard live in the top module.

## Test plan
- Reset release with no traffic → wb_valid=0, empty=1, pending=0, alu_clear=0.
- alu_valid with res=0x0000_0006, rd=5 → alu_clear high that cycle; next cycle wb_valid=1, wb_rd=5, wb_data=6; pops on wb_ready=1.
- wb_ready=0 and three results (rd=1,2,3) → first two captured; third is not acknowledged until a pop, then drains in order 1,2,3.
- Result with rd=0, error=0 → alu_clear=1 and no FIFO push. rd=0, error=1 → pushed with wb_error=1.
- Scoreboard build: issue rd=7 → pending[7]=1; its writeback accepted → pending[7]=0. Issue rd=7 in the same cycle as a writeback of rd=7 → pending[7] stays 1.
- flush with 2 entries queued and alu_valid high → alu_clear=1, FIFO empty next cycle, pending=0, no wb_valid.
